// File: rtl/armleocpu_csr_m.sv
// armleocpu_csr_m: machine/user CSR file with trap sequencing and cycle/instret counters
module armleocpu_csr_m #(
  parameter int          COUNTER_WIDTH = 64,
  parameter logic [31:0] MTVEC_RESET   = 32'h0000_0000,
  parameter int          HART_ID       = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  csr_cmd,
  input  logic [11:0] csr_address,
  input  logic [31:0] csr_writedata,
  input  logic [31:0] csr_exc_cause,
  input  logic [31:0] csr_exc_epc,
  input  logic        instret_incr,
  output logic        csr_invalid,
  output logic [31:0] csr_readdata,
  output logic [31:0] csr_next_pc,
  output logic [1:0]  csr_mcurrent_privilege,
  output logic [31:0] csr_mtvec,
  output logic [31:0] csr_mepc,
  output logic        csr_mstatus_mie
);
  localparam logic [3:0] CMD_WRITE = 4'd1, CMD_READ_SET = 4'd4, CMD_READ_CLEAR = 4'd5;
  localparam logic [3:0] CMD_MRET = 4'd6, CMD_EXC = 4'd7;
  logic mie, mpie, mapped, is_rd, is_wr, we;
  logic [1:0] mpp, priv, wv_mpp;
  logic [31:0] mtvec, mscratch, mepc, mcause, old, wv;
  logic [COUNTER_WIDTH-1:0] cycle, instret;
  logic [63:0] cyc64, ins64;
  assign cyc64 = 64'(cycle);
  assign ins64 = 64'(instret);
  always_comb begin
    mapped = 1'b1;
    old = '0;
    case (csr_address)
      12'h300: old = {19'b0, mpp, 3'b0, mpie, 3'b0, mie, 3'b0};
      12'h305: old = mtvec;
      12'h340: old = mscratch;
      12'h341: old = mepc;
      12'h342: old = mcause;
      12'hF14: old = 32'(HART_ID);
      12'hFC0: old = {30'b0, priv};
      12'hB00, 12'hC00: old = cyc64[31:0];
      12'hB80, 12'hC80: old = cyc64[63:32];
      12'hB02, 12'hC02: old = ins64[31:0];
      12'hB82, 12'hC82: old = ins64[63:32];
      default: mapped = 1'b0;
    endcase
  end
  assign is_rd = csr_cmd >= 4'd2 && csr_cmd <= 4'd5;
  assign is_wr = csr_cmd == CMD_WRITE || (csr_cmd >= 4'd3 && csr_cmd <= 4'd5);
  assign csr_invalid = ((is_rd || is_wr) && (!mapped || (is_wr && &csr_address[11:10]) || csr_address[9:8] > priv))
                     || (csr_cmd == CMD_MRET && priv == 2'b00);
  assign we = is_wr && !csr_invalid;
  assign wv = csr_cmd == CMD_READ_SET ? old | csr_writedata
            : csr_cmd == CMD_READ_CLEAR ? old & ~csr_writedata : csr_writedata;
  assign wv_mpp = (wv[12:11] == 2'b01 || wv[12:11] == 2'b10) ? mpp : wv[12:11];
  assign csr_readdata = (is_rd && !csr_invalid) ? old : '0;
  assign csr_next_pc = csr_cmd == CMD_MRET ? mepc : csr_cmd == CMD_EXC ? mtvec : '0;
  assign csr_mcurrent_privilege = priv;
  assign csr_mtvec = mtvec;
  assign csr_mepc = mepc;
  assign csr_mstatus_mie = mie;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mie <= 1'b0;
      mpie <= 1'b0;
      mpp <= 2'b11;
      priv <= 2'b11;
      mtvec <= MTVEC_RESET & ~32'h3;
      mscratch <= '0;
      mepc <= '0;
      mcause <= '0;
      cycle <= '0;
      instret <= '0;
    end else begin
      cycle <= (we && csr_address == 12'hB00) ? COUNTER_WIDTH'({cyc64[63:32], wv})
             : (we && csr_address == 12'hB80) ? COUNTER_WIDTH'({wv, cyc64[31:0]})
             : cycle + COUNTER_WIDTH'(1);
      instret <= (we && csr_address == 12'hB02) ? COUNTER_WIDTH'({ins64[63:32], wv})
               : (we && csr_address == 12'hB82) ? COUNTER_WIDTH'({wv, ins64[31:0]})
               : instret + COUNTER_WIDTH'(instret_incr);
      if (we && csr_address == 12'h300) begin
        mie <= wv[3];
        mpie <= wv[7];
        mpp <= wv_mpp;
      end
      if (we && csr_address == 12'h305) mtvec <= wv & ~32'h3;
      if (we && csr_address == 12'h340) mscratch <= wv;
      if (we && csr_address == 12'h341) mepc <= wv & ~32'h3;
      if (we && csr_address == 12'h342) mcause <= wv;
      if (csr_cmd == CMD_MRET && !csr_invalid) begin
        priv <= mpp;
        mie <= mpie;
        mpie <= 1'b1;
        mpp <= 2'b00;
      end
      if (csr_cmd == CMD_EXC) begin
        mepc <= csr_exc_epc & ~32'h3;
        mcause <= csr_exc_cause;
        mpie <= mie;
        mie <= 1'b0;
        mpp <= priv;
        priv <= 2'b11;
      end
    end
  end
endmodule

// File: tb/tb_armleocpu_csr_m.sv
// tb_armleocpu_csr_m: directed and randomized checks of armleocpu_csr_m against a behavioural model
module tb_armleocpu_csr_m;
  localparam logic [31:0] MTV = 32'h0000_1237;
  localparam logic [63:0] MASK = (64'h1 << 40) - 64'h1;
  localparam logic [3:0] C_NONE = 0, C_WR = 1, C_RD = 2, C_RW = 3, C_RS = 4, C_RC = 5, C_MRET = 6, C_EXC = 7;
  logic clk = 1'b0, rst_n = 1'b0, instret_incr = 1'b0;
  logic [3:0] csr_cmd = '0;
  logic [11:0] csr_address = '0;
  logic [31:0] csr_writedata = '0, csr_exc_cause = '0, csr_exc_epc = '0;
  logic csr_invalid, csr_mstatus_mie;
  logic [31:0] csr_readdata, csr_next_pc, csr_mtvec, csr_mepc;
  logic [1:0] csr_mcurrent_privilege;
  int n_vec = 0, n_err = 0;
  logic [31:0] m_mstatus, m_mtvec, m_scratch, m_mepc, m_mcause;
  logic [1:0] m_priv;
  logic [63:0] m_cyc, m_ins;
  logic [3:0] p_c;
  logic [11:0] p_a;
  logic [31:0] p_wv, p_cause, p_epc, e_rd, e_npc;
  logic p_inc, p_wr, e_inv;
  always #5 clk = ~clk;
  armleocpu_csr_m #(.COUNTER_WIDTH(40), .MTVEC_RESET(MTV), .HART_ID(5)) dut (
    .clk(clk), .rst_n(rst_n), .csr_cmd(csr_cmd), .csr_address(csr_address),
    .csr_writedata(csr_writedata), .csr_exc_cause(csr_exc_cause), .csr_exc_epc(csr_exc_epc),
    .instret_incr(instret_incr), .csr_invalid(csr_invalid), .csr_readdata(csr_readdata),
    .csr_next_pc(csr_next_pc), .csr_mcurrent_privilege(csr_mcurrent_privilege),
    .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc), .csr_mstatus_mie(csr_mstatus_mie));
  function automatic logic m_lookup(input logic [11:0] a, output logic [31:0] v);
    v = '0;
    m_lookup = 1'b1;
    case (a)
      12'h300: v = m_mstatus;
      12'h305: v = m_mtvec;
      12'h340: v = m_scratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'hF14: v = 32'd5;
      12'hFC0: v = {30'b0, m_priv};
      12'hB00, 12'hC00: v = m_cyc[31:0];
      12'hB80, 12'hC80: v = m_cyc[63:32];
      12'hB02, 12'hC02: v = m_ins[31:0];
      12'hB82, 12'hC82: v = m_ins[63:32];
      default: m_lookup = 1'b0;
    endcase
  endfunction
  task automatic drive(input logic [3:0] c, input logic [11:0] a, input logic [31:0] wd = 0,
                       input logic [31:0] cause = 0, input logic [31:0] epc = 0, input logic inc = 0);
    logic [31:0] old;
    logic mapped, rc, wc;
    rc = c inside {C_RD, C_RW, C_RS, C_RC};
    wc = c inside {C_WR, C_RW, C_RS, C_RC};
    mapped = m_lookup(a, old);
    e_inv = ((rc || wc) && (!mapped || (wc && a[11:10] == 2'b11) || a[9:8] > m_priv)) || (c == C_MRET && m_priv == 2'b00);
    e_rd = (rc && !e_inv) ? old : 32'h0;
    e_npc = c == C_MRET ? m_mepc : c == C_EXC ? m_mtvec : 32'h0;
    p_wv = c == C_RS ? old | wd : c == C_RC ? old & ~wd : wd;
    p_c = c; p_a = a; p_wr = wc && !e_inv; p_cause = cause; p_epc = epc; p_inc = inc;
    csr_cmd = c; csr_address = a; csr_writedata = wd; csr_exc_cause = cause; csr_exc_epc = epc; instret_incr = inc;
    #1;
  endtask
  task automatic tick();
    logic [63:0] nc, ni;
    logic [31:0] ns;
    @(posedge clk);
    if (!rst_n) begin
      m_mstatus = 32'h1800; m_mtvec = MTV & ~32'h3; m_scratch = 0; m_mepc = 0; m_mcause = 0;
      m_priv = 2'b11; m_cyc = 0; m_ins = 0;
    end else begin
      nc = (m_cyc + 1) & MASK;
      ni = (m_ins + 64'(p_inc)) & MASK;
      if (p_wr) begin
        case (p_a)
          12'h300: begin
            ns = p_wv & 32'h1888;
            if (ns[12:11] == 2'b01 || ns[12:11] == 2'b10) ns[12:11] = m_mstatus[12:11];
            m_mstatus = ns;
          end
          12'h305: m_mtvec = p_wv & ~32'h3;
          12'h340: m_scratch = p_wv;
          12'h341: m_mepc = p_wv & ~32'h3;
          12'h342: m_mcause = p_wv;
          12'hB00: nc = {m_cyc[63:32], p_wv};
          12'hB80: nc = {p_wv, m_cyc[31:0]} & MASK;
          12'hB02: ni = {m_ins[63:32], p_wv};
          12'hB82: ni = {p_wv, m_ins[31:0]} & MASK;
          default: ;
        endcase
      end
      if (p_c == C_MRET && !e_inv) begin
        m_priv = m_mstatus[12:11];
        m_mstatus = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
      end
      if (p_c == C_EXC) begin
        m_mepc = p_epc & ~32'h3;
        m_mcause = p_cause;
        m_mstatus = (32'(m_priv) << 11) | (m_mstatus[3] ? 32'h80 : 32'h0);
        m_priv = 2'b11;
      end
      m_cyc = nc;
      m_ins = ni;
    end
    #1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    drive(C_WR, 12'h340, 32'hDEAD_BEEF); tick(); tick();
    n_vec++; if (csr_mcurrent_privilege !== 2'b11) begin n_err++; $display("FAIL rst_priv: got %h exp 3", csr_mcurrent_privilege); end
    n_vec++; if (csr_mtvec !== 32'h1234) begin n_err++; $display("FAIL rst_mtvec: got %h exp 00001234", csr_mtvec); end
    n_vec++; if (csr_mstatus_mie !== 1'b0 || csr_mepc !== 32'h0) begin n_err++; $display("FAIL rst_mie_mepc: got %b %h exp 0 0", csr_mstatus_mie, csr_mepc); end
    rst_n = 1'b1;
    drive(C_RD, 12'hFC0);
    n_vec++; if (csr_readdata !== 32'h3 || csr_invalid !== 1'b0) begin n_err++; $display("FAIL rd_priv: got %h inv %b exp 3 inv 0", csr_readdata, csr_invalid); end
    tick(); drive(C_RD, 12'h305);
    n_vec++; if (csr_readdata !== 32'h1234) begin n_err++; $display("FAIL rd_mtvec: got %h exp 00001234", csr_readdata); end
    tick(); drive(C_RD, 12'h300);
    n_vec++; if (csr_readdata !== 32'h1800) begin n_err++; $display("FAIL rd_mstatus: got %h exp 00001800", csr_readdata); end
    tick(); drive(C_RD, 12'h340);
    n_vec++; if (csr_readdata !== 32'h0) begin n_err++; $display("FAIL rst_cmd_discard: got %h exp 0", csr_readdata); end
    tick(); drive(C_RD, 12'hF14);
    n_vec++; if (csr_readdata !== 32'h5) begin n_err++; $display("FAIL rd_hartid: got %h exp 5", csr_readdata); end
    tick();
  endtask
  task automatic test_mscratch();
    drive(C_WR, 12'h340, 32'hA5A5_0F0F);
    n_vec++; if (csr_readdata !== 32'h0) begin n_err++; $display("FAIL write_rd_zero: got %h exp 0", csr_readdata); end
    tick(); drive(C_RS, 12'h340, 32'h0000_F000);
    n_vec++; if (csr_readdata !== 32'hA5A5_0F0F) begin n_err++; $display("FAIL rs_old: got %h exp a5a50f0f", csr_readdata); end
    tick(); drive(C_RC, 12'h340, 32'hA500_0000);
    n_vec++; if (csr_readdata !== 32'hA5A5_FF0F) begin n_err++; $display("FAIL rc_old: got %h exp a5a5ff0f", csr_readdata); end
    tick(); drive(C_RD, 12'h340);
    n_vec++; if (csr_readdata !== 32'h00A5_FF0F) begin n_err++; $display("FAIL rc_final: got %h exp 00a5ff0f", csr_readdata); end
    tick();
  endtask
  task automatic test_exception_mret();
    drive(C_WR, 12'h300, 32'h1808); tick();
    drive(C_EXC, 12'h0, 32'h0, 32'h2, 32'h1003);
    n_vec++; if (csr_next_pc !== 32'h1234 || csr_invalid !== 1'b0) begin n_err++; $display("FAIL exc_pc: got %h inv %b exp 00001234 inv 0", csr_next_pc, csr_invalid); end
    tick();
    n_vec++; if (csr_mepc !== 32'h1000 || csr_mstatus_mie !== 1'b0) begin n_err++; $display("FAIL exc_state: got mepc %h mie %b exp 00001000 0", csr_mepc, csr_mstatus_mie); end
    drive(C_RD, 12'h300);
    n_vec++; if (csr_readdata !== 32'h1880) begin n_err++; $display("FAIL exc_mstatus: got %h exp 00001880", csr_readdata); end
    tick(); drive(C_RD, 12'h342);
    n_vec++; if (csr_readdata !== 32'h2) begin n_err++; $display("FAIL exc_mcause: got %h exp 2", csr_readdata); end
    tick(); drive(C_WR, 12'h300, 32'h0080); tick();
    drive(C_MRET, 12'h0);
    n_vec++; if (csr_next_pc !== 32'h1000 || csr_invalid !== 1'b0) begin n_err++; $display("FAIL mret_pc: got %h inv %b exp 00001000 inv 0", csr_next_pc, csr_invalid); end
    tick();
    n_vec++; if (csr_mcurrent_privilege !== 2'b00 || csr_mstatus_mie !== 1'b1) begin n_err++; $display("FAIL mret_state: got priv %h mie %b exp 0 1", csr_mcurrent_privilege, csr_mstatus_mie); end
  endtask
  task automatic test_user();
    drive(C_RD, 12'h340);
    n_vec++; if (csr_invalid !== 1'b1) begin n_err++; $display("FAIL user_rd_mscratch: got inv %b exp 1", csr_invalid); end
    tick(); drive(C_MRET, 12'h0);
    n_vec++; if (csr_invalid !== 1'b1) begin n_err++; $display("FAIL user_mret: got inv %b exp 1", csr_invalid); end
    tick();
    n_vec++; if (csr_mcurrent_privilege !== 2'b00) begin n_err++; $display("FAIL user_priv_hold: got %h exp 0", csr_mcurrent_privilege); end
    drive(C_RD, 12'hC00);
    n_vec++; if (csr_invalid !== 1'b0 || csr_readdata !== m_cyc[31:0]) begin n_err++; $display("FAIL user_rd_cycle: got %h inv %b exp %h inv 0", csr_readdata, csr_invalid, m_cyc[31:0]); end
    tick(); drive(C_WR, 12'hC00, 32'h1);
    n_vec++; if (csr_invalid !== 1'b1) begin n_err++; $display("FAIL user_wr_cycle: got inv %b exp 1", csr_invalid); end
    tick(); drive(C_EXC, 12'h0, 32'h0, 32'h8, 32'h2000); tick();
    n_vec++; if (csr_mcurrent_privilege !== 2'b11) begin n_err++; $display("FAIL exc_from_user: got %h exp 3", csr_mcurrent_privilege); end
    drive(C_RD, 12'h340);
    n_vec++; if (csr_readdata !== 32'h00A5_FF0F) begin n_err++; $display("FAIL user_scratch_kept: got %h exp 00a5ff0f", csr_readdata); end
    tick(); drive(C_RD, 12'h300);
    n_vec++; if (csr_readdata !== 32'h0080) begin n_err++; $display("FAIL exc_mpp_user: got %h exp 00000080", csr_readdata); end
    tick();
  endtask
  task automatic test_counters();
    drive(C_WR, 12'hB80, 32'hFFFF_FFFF); tick(); drive(C_RD, 12'hB80);
    n_vec++; if (csr_readdata !== 32'hFF) begin n_err++; $display("FAIL cyc_hi_mask: got %h exp 000000ff", csr_readdata); end
    tick(); drive(C_WR, 12'hB00, 32'hFFFF_FFFF); tick(); drive(C_RD, 12'hB00);
    n_vec++; if (csr_readdata !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL cyc_hold: got %h exp ffffffff", csr_readdata); end
    tick(); drive(C_RD, 12'hB80);
    n_vec++; if (csr_readdata !== 32'h0) begin n_err++; $display("FAIL cyc_wrap_hi: got %h exp 0", csr_readdata); end
    tick(); drive(C_RD, 12'hB00);
    n_vec++; if (csr_readdata !== 32'h1) begin n_err++; $display("FAIL cyc_wrap_lo: got %h exp 1", csr_readdata); end
    tick(); drive(C_WR, 12'hB02, 32'h5, 0, 0, 1'b1); tick(); drive(C_RD, 12'hB02, 0, 0, 0, 1'b1);
    n_vec++; if (csr_readdata !== 32'h5) begin n_err++; $display("FAIL ins_collide: got %h exp 5", csr_readdata); end
    tick(); drive(C_RD, 12'hC02);
    n_vec++; if (csr_readdata !== 32'h6) begin n_err++; $display("FAIL ins_incr: got %h exp 6", csr_readdata); end
    tick();
  endtask
  task automatic test_warl_unmapped();
    drive(C_WR, 12'h300, 32'h1800); tick(); drive(C_WR, 12'h300, 32'h0800); tick(); drive(C_RD, 12'h300);
    n_vec++; if (csr_readdata !== 32'h1800) begin n_err++; $display("FAIL warl_01: got %h exp 00001800", csr_readdata); end
    tick(); drive(C_WR, 12'h300, 32'h1000); tick(); drive(C_RD, 12'h300);
    n_vec++; if (csr_readdata !== 32'h1800) begin n_err++; $display("FAIL warl_10: got %h exp 00001800", csr_readdata); end
    tick(); drive(C_RD, 12'h7FF);
    n_vec++; if (csr_invalid !== 1'b1 || csr_readdata !== 32'h0) begin n_err++; $display("FAIL unmapped: got %h inv %b exp 0 inv 1", csr_readdata, csr_invalid); end
    tick(); drive(C_WR, 12'h305, 32'h2003); tick();
    n_vec++; if (csr_mtvec !== 32'h2000) begin n_err++; $display("FAIL mtvec_wr: got %h exp 00002000", csr_mtvec); end
  endtask
  task automatic test_random();
    logic [11:0] addrs [18] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hF14, 12'hFC0, 12'hB00, 12'hB80,
                                12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'h7FF, 12'h301, 12'h000};
    for (int i = 0; i < 400; i++) begin
      drive(4'($urandom_range(0, 15)), addrs[$urandom_range(0, 17)], $urandom, $urandom, $urandom, 1'($urandom));
      n_vec++; if (csr_readdata !== e_rd || csr_invalid !== e_inv || csr_next_pc !== e_npc) begin
        n_err++; $display("FAIL rand_comb %0d: cmd %h addr %h got rd %h inv %b pc %h exp rd %h inv %b pc %h", i, p_c, p_a, csr_readdata, csr_invalid, csr_next_pc, e_rd, e_inv, e_npc); end
      tick();
      n_vec++; if (csr_mtvec !== m_mtvec || csr_mepc !== m_mepc || csr_mstatus_mie !== m_mstatus[3] || csr_mcurrent_privilege !== m_priv) begin
        n_err++; $display("FAIL rand_state %0d: got %h %h %b %h exp %h %h %b %h", i, csr_mtvec, csr_mepc, csr_mstatus_mie, csr_mcurrent_privilege, m_mtvec, m_mepc, m_mstatus[3], m_priv); end
    end
  endtask
  initial begin
    test_reset();
    test_mscratch();
    test_exception_mret();
    test_user();
    test_counters();
    test_warl_unmapped();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/armleocpu_csr_m.md
# armleocpu_csr_m

Machine/user-mode CSR file for the ArmleoCPU execute stage. It decodes CSR-class commands from execute: reads are combinational, and updates commit on the next clock edge. It holds the trap state (mstatus, mtvec, mepc, mcause), the hart privilege, and free-running cycle/instret counters of parametrised width. It also sequences MRET and exception entry, and presents the redirect PC to fetch.

## Interface
- COUNTER_WIDTH, 64: cycle/instret counter width, legal 33..64; bits above the width read 0.
- MTVEC_RESET, 32'h0000_0000: reset value of mtvec; bits [1:0] are forced to 0.
- HART_ID, 0: value returned by mhartid.
- clk  in  1  clock, all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- csr_cmd  in  4  command: 0 NONE, 1 WRITE, 2 READ, 3 READ_WRITE, 4 READ_SET, 5 READ_CLEAR, 6 MRET, 7 EXCEPTION_BEGIN; 8..15 are treated as NONE.
- csr_address  in  12  CSR number.
- csr_writedata  in  32  write/set/clear operand.
- csr_exc_cause  in  32  mcause value for EXCEPTION_BEGIN.
- csr_exc_epc  in  32  faulting PC for EXCEPTION_BEGIN.
- instret_incr  in  1  an instruction retired this cycle.
- csr_invalid  out  1  the command is illegal; no state changes.
- csr_readdata  out  32  old value of the addressed CSR.
- csr_next_pc  out  32  redirect target, valid for MRET/EXCEPTION_BEGIN; 0 otherwise.
- csr_mcurrent_privilege  out  2  2'b11 machine, 2'b00 user.
- csr_mtvec, csr_mepc  out  32  current register values.
- csr_mstatus_mie  out  1  global interrupt enable.

## Operation
- **CSR map and reset values:**
  - mstatus 0x300: MIE[3], MPIE[7], MPP[12:11]; other bits read 0; reset MIE=0, MPIE=0, MPP=2'b11.
  - mtvec 0x305: reset MTVEC_RESET.
  - mscratch 0x340: reset 0.
  - mepc 0x341: [1:0] read 0; reset 0.
  - mcause 0x342: reset 0.
  - mhartid 0xF14: read-only.
  - mcurrent_privilege 0xFC0: read-only; reset 2'b11.
  - mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82: read-write; reset 0.
  - cycle/cycleh 0xC00/0xC80, instret/instreth 0xC02/0xC82: read-only shadows, readable at any privilege.
- **Read** (READ, READ_WRITE, READ_SET, READ_CLEAR): csr_readdata is the pre-update value. For all other commands csr_readdata is 0.
- **Write value:**
  - WRITE and READ_WRITE write the operand.
  - READ_SET writes old | operand.
  - READ_CLEAR writes old & ~operand.
  - Decode issues READ instead when rs1 is x0.
- **csr_invalid=1** when any of the following holds:
  - The address is unmapped and the command is a read or write class.
  - A write-class command targets an address with [11:10]==2'b11.
  - address[9:8] is greater than the current privilege (user access to any 0x3xx/0xBxx/0xFxx).
  - The command is MRET while in user mode.
- Invalid commands change no state.
- **MPP is WARL:** a written value of 01 or 10 keeps the old MPP.
- **Counters:**
  - The cycle counter increments every cycle; instret increments when instret_incr=1. Both wrap from 2^COUNTER_WIDTH-1 to 0.
  - A write to the low or high half replaces only that half, and that counter does not increment in that cycle.
  - High-half bits at or above COUNTER_WIDTH-32 ignore writes.
- **MRET:**
  - privilege ← MPP; MIE ← MPIE; MPIE ← 1; MPP ← 2'b00.
  - csr_next_pc = mepc.
- **EXCEPTION_BEGIN:**
  - mepc ← exc_epc & ~3; mcause ← exc_cause.
  - MPIE ← MIE; MIE ← 0; MPP ← current privilege; privilege ← 2'b11.
  - csr_next_pc = mtvec. It is never invalid.

## Timing
- csr_readdata, csr_invalid and csr_next_pc are combinational from the inputs and the current state, with zero latency.
- All state updates land on the next rising edge. A read of the same CSR one cycle after a write returns the new value.
- During reset (rst_n=0) all registers load their reset values on every edge. A command issued in a reset cycle is discarded, and the counters hold 0.
- Outputs reflect the reset state from the first edge with rst_n=0.
- No handshake is used: one command per cycle, and the caller holds no state.

## Test plan
- **Reset then read:** release reset, then READ 0xFC0 → readdata=3, invalid=0. READ 0x305 → MTVEC_RESET with [1:0]=0. READ 0x300 → 0x0000_1800.
- **mscratch set/clear:**
  - WRITE 0x340 = 0xA5A5_0F0F, then READ_SET 0x0000_F000 → readdata=0xA5A5_0F0F.
  - READ_CLEAR 0xA500_0000 → readdata=0xA5A5_FF0F; a final READ returns 0x00A5_FF0F.
- **Exception then MRET:**
  - From machine mode with MIE=1, EXCEPTION_BEGIN with epc=0x1003, cause=2 → next_pc=mtvec. The cycle after: mepc=0x1000, MPIE=1, MIE=0, MPP=3.
  - WRITE mstatus MPP=0, then MRET → next_pc=0x1000, privilege=0, MIE=1.
- **User access checks:**
  - In user mode, READ 0x340 → invalid=1 and mscratch unchanged. MRET → invalid=1 and privilege stays 0.
  - READ 0xC00 → invalid=0. WRITE 0xC00 → invalid=1.
- **Counter wrap and write collision:**
  - With COUNTER_WIDTH=40, WRITE mcycleh=0xFF and mcycle=0xFFFF_FFFF → mcycle holds, then wraps to 0 on the next cycle, and mcycleh reads 0.
  - instret_incr=1 in the same cycle as a WRITE to minstret=5 → minstret=5.
- **WARL and unmapped addresses:** WRITE mstatus with MPP=01 → MPP is unchanged. READ 0x7FF → invalid=1 and readdata=0.
